conv2d_axi_lite_seq: RTL and testbench
======================================

Name: conv2d_axi_lite_seq

Overview:
Parametrised AXI4-Lite slave wrapping a time-multiplexed convolution MAC engine: one DSP multiplier walks TAPS pixel/weight pairs, one tap per cycle. Adds what the fixed 3x3 single-cycle wrapper lacked: independent AW/W acceptance, proper ready/valid, start pulse, sticky done with W1C, configurable shift/ReLU/saturation, SLVERR on bad or illegal accesses, and an interrupt. Sits on the ARM PS GP port as the next-generation accelerator endpoint.

Parameters:
TAPS, 9, number of pixel/weight pairs (1..16)
DATA_W, 8, signed pixel and weight width (2..16)
ACC_W, 24, signed accumulator width (>= 2*DATA_W + clog2(TAPS))
OUT_W, 16, signed saturated result width (<= 32)
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 8, AXI address width

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data (WSTRB not supported; full-word writes)
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake
irq  out  1  level interrupt = done & irq_en

Behaviour:
- Reset (async assert, sync release): all READY/VALID 0, BRESP/RRESP/RDATA 0, irq 0; busy=0, done=0, cfg=0, acc=0, result=0; IN/W arrays cleared to 0.
- Map (word offsets): 0x00 CTRL W: bit0 start (W1S, self-clearing), bit1 done W1C; R: {busy[2], done[1], 0}. 0x04 CFG RW: [4:0] shift, [8] relu_en, [9] irq_en. 0x08 OUT RO: result sign-extended to 32. 0x0C ID RO: {TAPS[7:0], DATA_W[7:0], 16'hC2D2}. 0x40+4i IN[i], 0x80+4i W[i], i<TAPS: write takes WDATA[DATA_W-1:0]; read returns sign-extended value.
- SLVERR: unmapped or i>=TAPS address (write dropped, read data 0); write to CFG/IN/W or start=1 while busy (write dropped). Writes to OUT/ID: SLVERR.
- Write channel: AW and W accepted independently; AWREADY=1 when no address latched and BVALID=0; WREADY likewise for data. Commit in the cycle both are latched; BVALID asserts next cycle, held until BREADY; new AW/W not accepted while BVALID=1.
- Read channel: ARREADY=1 when RVALID=0 and no read pending; data captured on AR handshake, RVALID next cycle, RDATA/RRESP stable until RREADY.
- FSM IDLE -> RUN on committed start (busy=1, done cleared, acc=0, idx=0, next cycle). RUN: acc += IN[idx]*W[idx], idx++; after TAPS products -> FIN. FIN: result = sat_OUT_W(relu(acc >>> shift)), done=1, busy=0 -> IDLE. Start commit to done visible = TAPS+2 cycles.
- Arithmetic: signed throughout; arithmetic right shift; relu clamps negatives to 0 before saturation; saturation to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Simultaneous W1C done and FIN in same cycle: done set wins. Start and done-clear in same write: clear then start (done=0, busy=1).
- Reset mid-RUN: abort immediately, all state to reset values; outstanding AXI transactions dropped.

Decomposition:
- Package conv_axi_pkg: register offsets, IN/W base addresses, RESP_OKAY/RESP_SLVERR, FSM state enum (IDLE, RUN, FIN), ID magic 16'hC2D2, saturate/relu functions.
- Sub-module conv_mac_seq: sequential MAC engine (start, operand arrays, cfg in; busy, done_pulse, result out); wrapper owns AXI and register file.

Test Plan:
- Load IN=1..9, W=all 1, shift 0, start -> busy for 9 cycles, done at commit+11, OUT=45, BRESP OKAY for all 20 writes.
- IN all -128, W all -128, TAPS=9 -> acc 147456 -> OUT saturates to 32767; relu_en with W=+127 -> OUT=0.
- AW issued 3 cycles before W, then W before AW, BREADY held low 5 cycles -> single commit each, BVALID held, no duplicate write.
- Write W[0] and start while busy -> both SLVERR, result unaffected; read 0xFC -> RRESP SLVERR, RDATA 0.
- irq_en=1, run to done -> irq=1; write CTRL=0x2 -> done=0, irq=0 next cycle; FIN coincident with W1C -> done stays 1.
- Assert S_AXI_ARESET mid-RUN (cycle 4) -> busy, done, OUT, READY/VALID all 0 immediately; fresh run afterward produces correct result.

Source files
------------

// File: rtl/conv_axi_pkg.sv
// Shared definitions for the sequential convolution AXI4-Lite accelerator:
// register map, response codes, engine state and the result post-processing helpers.
package conv_axi_pkg;

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_CFG  = 8'h04;
  localparam logic [7:0] OFF_OUT  = 8'h08;
  localparam logic [7:0] OFF_ID   = 8'h0C;
  localparam logic [7:0] BASE_IN  = 8'h40;
  localparam logic [7:0] BASE_W   = 8'h80;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [15:0] ID_MAGIC = 16'hC2D2;

  typedef enum logic [1:0] {StIdle, StRun, StFin} mac_state_e;

  typedef enum logic [2:0] {SelCtrl, SelCfg, SelOut, SelId, SelIn, SelW, SelNone} reg_sel_e;

  function automatic logic signed [63:0] relu(input logic signed [63:0] v, input logic en);
    return (en && (v < 0)) ? 64'sd0 : v;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv2d_axi_lite_seq_if.sv
// AXI4-Lite bus bundle for the convolution accelerator; master drives requests, slave responds.
interface conv2d_axi_lite_seq_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/conv_mac_seq.sv
// Time-multiplexed MAC: one multiplier walks TAPS operand pairs, then shifts, rectifies and
// saturates the accumulator into the result register.
module conv_mac_seq
  import conv_axi_pkg::*;
#(
  parameter int unsigned TAPS   = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] in_arr [TAPS],
  input  logic signed [DATA_W-1:0] w_arr  [TAPS],
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done_pulse,
  output logic signed [OUT_W-1:0]  result
);

  localparam int unsigned IdxW = (TAPS > 1) ? $clog2(TAPS) : 1;

  mac_state_e              state_q;
  logic [IdxW-1:0]         idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [63:0]      acc_ext;
  logic signed [63:0]      post;

  always_comb begin
    acc_ext = 64'(acc_q);
    post    = saturate(relu(acc_ext >>> shift, relu_en), OUT_W);
  end

  // Lets the wrapper set sticky done on the same edge the result lands.
  assign done_pulse = (state_q == StFin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      result  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            acc_q   <= '0;
            idx_q   <= '0;
          end
        end
        StRun: begin
          acc_q <= acc_q + ACC_W'(in_arr[idx_q] * w_arr[idx_q]);
          idx_q <= idx_q + 1'b1;
          if (idx_q == IdxW'(TAPS - 1)) state_q <= StFin;
        end
        StFin: begin
          result  <= OUT_W'(post);
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/conv2d_axi_lite_seq.sv
// AXI4-Lite register front end for the sequential convolution engine: independent AW/W capture,
// register file, start/done control, SLVERR policing and level interrupt.
module conv2d_axi_lite_seq
  import conv_axi_pkg::*;
#(
  parameter int unsigned TAPS               = 9,
  parameter int unsigned DATA_W             = 8,
  parameter int unsigned ACC_W              = 24,
  parameter int unsigned OUT_W              = 16,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  conv2d_axi_lite_seq_if.slave s_axi,
  output logic                 irq
);

  logic                          en_q;
  logic                          aw_q, w_q, bvalid_q, rvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, rdata_q, rd_data;
  logic [1:0]                    bresp_q, rresp_q;
  logic                          start_q, done_q, relu_q, irq_en_q;
  logic [4:0]                    shift_q;
  logic signed [DATA_W-1:0]      in_q [TAPS];
  logic signed [DATA_W-1:0]      wt_q [TAPS];
  logic                          mac_busy, done_pulse, busy, commit, wr_err;
  logic signed [OUT_W-1:0]       result;
  reg_sel_e                      wr_sel, rd_sel;
  logic [3:0]                    wr_idx, rd_idx;

  function automatic reg_sel_e decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (((a >> 8) != '0) || (lo[1:0] != 2'b00)) return SelNone;
    case (lo)
      OFF_CTRL: return SelCtrl;
      OFF_CFG:  return SelCfg;
      OFF_OUT:  return SelOut;
      OFF_ID:   return SelId;
      default:  ;
    endcase
    if (32'(lo[5:2]) < TAPS) begin
      if (lo[7:6] == BASE_IN[7:6]) return SelIn;
      if (lo[7:6] == BASE_W[7:6]) return SelW;
    end
    return SelNone;
  endfunction

  // A latched start counts as busy until the engine picks it up.
  assign busy   = mac_busy | start_q;
  assign commit = aw_q & w_q;
  assign wr_sel = decode(awaddr_q);
  assign wr_idx = awaddr_q[5:2];
  assign rd_sel = decode(s_axi.S_AXI_ARADDR);
  assign rd_idx = s_axi.S_AXI_ARADDR[5:2];

  always_comb begin
    wr_err = 1'b0;
    case (wr_sel)
      SelCtrl:             wr_err = wdata_q[0] & busy;
      SelCfg, SelIn, SelW: wr_err = busy;
      default:             wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SelCtrl: rd_data = {29'd0, busy, done_q, 1'b0};
      SelCfg:  rd_data = {22'd0, irq_en_q, relu_q, 3'd0, shift_q};
      SelOut:  rd_data = 32'(result);
      SelId:   rd_data = {8'(TAPS), 8'(DATA_W), ID_MAGIC};
      SelIn:   rd_data = 32'(in_q[rd_idx]);
      SelW:    rd_data = 32'(wt_q[rd_idx]);
      default: rd_data = '0;
    endcase
  end

  assign s_axi.S_AXI_AWREADY = en_q & ~aw_q & ~bvalid_q;
  assign s_axi.S_AXI_WREADY  = en_q & ~w_q & ~bvalid_q;
  assign s_axi.S_AXI_ARREADY = en_q & ~rvalid_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign irq                 = done_q & irq_en_q;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      en_q     <= 1'b0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      irq_en_q <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        in_q[i] <= '0;
        wt_q[i] <= '0;
      end
    end else begin
      en_q    <= 1'b1;
      start_q <= 1'b0;
      if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY) begin
        aw_q     <= 1'b1;
        awaddr_q <= s_axi.S_AXI_AWADDR;
      end
      if (s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY) begin
        w_q     <= 1'b1;
        wdata_q <= s_axi.S_AXI_WDATA;
      end
      if (commit) begin
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          case (wr_sel)
            SelCtrl: begin
              if (wdata_q[1] || wdata_q[0]) done_q <= 1'b0;
              start_q <= wdata_q[0];
            end
            SelCfg: begin
              shift_q  <= wdata_q[4:0];
              relu_q   <= wdata_q[8];
              irq_en_q <= wdata_q[9];
            end
            SelIn:   in_q[wr_idx] <= wdata_q[DATA_W-1:0];
            SelW:    wt_q[wr_idx] <= wdata_q[DATA_W-1:0];
            default: ;
          endcase
        end
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      // Completion outranks a W1C landing on the same edge.
      if (done_pulse) done_q <= 1'b1;
      if (s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= (rd_sel == SelNone) ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  conv_mac_seq #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk        (S_AXI_ACLK),
    .rst        (S_AXI_ARESET),
    .start      (start_q),
    .in_arr     (in_q),
    .w_arr      (wt_q),
    .shift      (shift_q),
    .relu_en    (relu_q),
    .busy       (mac_busy),
    .done_pulse (done_pulse),
    .result     (result)
  );

endmodule

// File: tb/tb_conv2d_axi_lite_seq.sv
// Randomised bench for conv2d_axi_lite_seq against an arithmetic reference of the convolution.
module tb_conv2d_axi_lite_seq;

  localparam int TAPS = 9;
  localparam logic [7:0] A_CTRL = 8'h00, A_CFG = 8'h04, A_OUT = 8'h08, A_ID = 8'h0C;
  localparam logic [7:0] A_IN = 8'h40, A_W = 8'h80;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic irq;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   bv_cycle;

  int in_m [TAPS];
  int w_m  [TAPS];
  int shift_m;
  bit relu_m, irq_en_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_axi_lite_seq_if #(.ADDR_W(8)) bus ();

  conv2d_axi_lite_seq #(
    .TAPS               (TAPS),
    .DATA_W             (8),
    .ACC_W              (24),
    .OUT_W              (16),
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (8)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus),
    .irq          (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected OUT: dot product, arithmetic shift, optional ReLU, clamp to 16-bit signed.
  function automatic logic [31:0] model_out();
    longint acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(in_m[i]) * longint'(w_m[i]);
    acc = acc >>> shift_m;
    if (relu_m && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 32'(acc);
  endfunction

  task automatic aw_send(input logic [7:0] a, input int dly);
    bit ok;
    int n = 0;
    repeat (dly) @(negedge clk);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    while (1) begin
      ok = bus.S_AXI_AWREADY;
      @(posedge clk);
      if (ok) break;
      if (++n > 60) begin check_eq("aw_timeout", {31'd0, ok}, 1); break; end
    end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input int dly);
    bit ok;
    int n = 0;
    repeat (dly) @(negedge clk);
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WVALID = 1'b1;
    while (1) begin
      ok = bus.S_AXI_WREADY;
      @(posedge clk);
      if (ok) break;
      if (++n > 60) begin check_eq("w_timeout", {31'd0, ok}, 1); break; end
    end
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input int aw_dly,
                           input int w_dly, input int b_dly, output logic [1:0] resp);
    int n = 0;
    fork
      aw_send(a, aw_dly);
      w_send(d, w_dly);
    join
    while (!bus.S_AXI_BVALID && n < 40) begin @(negedge clk); n++; end
    if (!bus.S_AXI_BVALID) begin
      check_eq("b_timeout", {31'd0, bus.S_AXI_BVALID}, 1);
      resp = 2'b11;
      return;
    end
    bv_cycle = cyc;
    resp     = bus.S_AXI_BRESP;
    repeat (b_dly) begin
      @(negedge clk);
      check_eq("b_hold", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY}, 32'd2);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [1:0] exp_resp,
                    input string tag);
    logic [1:0] r;
    axi_write(a, d, 0, 0, 0, r);
    check_eq(tag, {30'd0, r}, {30'd0, exp_resp});
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    int n = 0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    while (1) begin
      ok = bus.S_AXI_ARREADY;
      @(posedge clk);
      if (ok) break;
      if (++n > 60) begin check_eq("ar_timeout", {31'd0, ok}, 1); break; end
    end
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 40) begin @(negedge clk); n++; end
    if (!bus.S_AXI_RVALID) check_eq("r_timeout", {31'd0, bus.S_AXI_RVALID}, 1);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                        input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check_eq({tag, "_data"}, d, exp_d);
    check_eq({tag, "_resp"}, {30'd0, r}, {30'd0, exp_r});
  endtask

  task automatic set_cfg(input int sh, input bit relu, input bit ien);
    shift_m  = sh;
    relu_m   = relu;
    irq_en_m = ien;
    wr(A_CFG, {22'd0, ien, relu, 3'd0, 5'(sh)}, OKAY, "cfg_wr");
  endtask

  task automatic load_ops(input bit rand_timing);
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < TAPS; i++) begin
      for (int k = 0; k < 2; k++) begin
        d = $urandom();
        d[7:0] = (k == 0) ? in_m[i][7:0] : w_m[i][7:0];
        if (rand_timing)
          axi_write((k == 0 ? A_IN : A_W) + 8'(4 * i), d, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 2), r);
        else
          axi_write((k == 0 ? A_IN : A_W) + 8'(4 * i), d, 0, 0, 0, r);
        check_eq("load_resp", {30'd0, r}, {30'd0, OKAY});
      end
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    int n = 0;
    d = '0;
    while (n < 40) begin
      axi_read(A_CTRL, d, r);
      if (d[1]) break;
      n++;
    end
    check_eq({tag, "_done"}, {31'd0, d[1]}, 1);
  endtask

  task automatic run_conv(input string tag);
    wr(A_CTRL, 32'h1, OKAY, {tag, "_start"});
    wait_done(tag);
    rd_chk(A_OUT, model_out(), OKAY, {tag, "_out"});
  endtask

  task automatic bus_idle();
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    check_eq(tag, {26'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                   bus.S_AXI_BVALID, bus.S_AXI_RVALID, irq}, 32'd0);
    check_eq({tag, "_rdata"}, bus.S_AXI_RDATA ^ {28'd0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    int sb, d;

    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("rst_quiet");
    rst = 1'b0;
    @(negedge clk);
    rd_chk(A_CTRL, 32'h0, OKAY, "rst_ctrl");
    rd_chk(A_CFG, 32'h0, OKAY, "rst_cfg");
    rd_chk(A_OUT, 32'h0, OKAY, "rst_out");
    rd_chk(A_IN, 32'h0, OKAY, "rst_in0");
    rd_chk(A_W + 8'd32, 32'h0, OKAY, "rst_w8");
    rd_chk(A_ID, 32'h0908C2D2, OKAY, "id");

    // Ramp times ones, with latency measured on irq.
    for (int i = 0; i < TAPS; i++) begin in_m[i] = i + 1; w_m[i] = 1; end
    set_cfg(0, 0, 1);
    load_ops(0);
    wr(A_CTRL, 32'h1, OKAY, "ramp_start");
    sb = bv_cycle;
    rd_chk(A_CTRL, 32'h4, OKAY, "ramp_busy");
    d = 0;
    while (!irq && d < 40) begin @(negedge clk); d++; end
    check_eq("ramp_latency", 32'(cyc - sb), 32'(TAPS + 2));
    rd_chk(A_OUT, 32'd45, OKAY, "ramp_out");
    rd_chk(A_CTRL, 32'h2, OKAY, "ramp_ctrl_done");
    check_eq("irq_set", {31'd0, irq}, 1);
    wr(A_CTRL, 32'h2, OKAY, "w1c");
    check_eq("irq_clr", {31'd0, irq}, 0);
    rd_chk(A_CTRL, 32'h0, OKAY, "w1c_ctrl");

    // Saturation corners.
    for (int i = 0; i < TAPS; i++) begin in_m[i] = -128; w_m[i] = -128; end
    set_cfg(0, 0, 0);
    load_ops(0);
    run_conv("sat_pos");
    for (int i = 0; i < TAPS; i++) w_m[i] = 127;
    load_ops(0);
    run_conv("sat_neg");
    set_cfg(0, 1, 0);
    run_conv("relu_zero");

    // Independent AW/W ordering with a stalled B channel.
    in_m[2] = $urandom_range(0, 255) - 128;
    axi_write(A_IN + 8'd8, {24'hABCDEF, 8'(in_m[2])}, 0, 3, 5, r);
    check_eq("aw_first_resp", {30'd0, r}, {30'd0, OKAY});
    @(negedge clk);
    check_eq("aw_first_single", {31'd0, bus.S_AXI_BVALID}, 0);
    rd_chk(A_IN + 8'd8, 32'(in_m[2]), OKAY, "aw_first_rb");
    w_m[3] = $urandom_range(0, 255) - 128;
    axi_write(A_W + 8'd12, {24'h123456, 8'(w_m[3])}, 3, 0, 5, r);
    check_eq("w_first_resp", {30'd0, r}, {30'd0, OKAY});
    @(negedge clk);
    check_eq("w_first_single", {31'd0, bus.S_AXI_BVALID}, 0);
    rd_chk(A_W + 8'd12, 32'(w_m[3]), OKAY, "w_first_rb");

    // Illegal accesses while busy and to unmapped space.
    set_cfg(2, 0, 0);
    wr(A_CTRL, 32'h1, OKAY, "busy_start0");
    wr(A_W, 32'h7F, SLVERR, "busy_w0");
    wr(A_CTRL, 32'h1, SLVERR, "busy_restart");
    wr(A_CFG, 32'h0, SLVERR, "busy_cfg");
    wait_done("busy");
    rd_chk(A_OUT, model_out(), OKAY, "busy_out");
    rd_chk(A_CFG, 32'h2, OKAY, "busy_cfg_kept");
    rd_chk(8'hFC, 32'h0, SLVERR, "rd_unmapped");
    rd_chk(A_IN + 8'd36, 32'h0, SLVERR, "rd_in_oob");
    rd_chk(8'h41, 32'h0, SLVERR, "rd_unaligned");
    wr(A_OUT, 32'h1, SLVERR, "wr_out");
    wr(A_ID, 32'h1, SLVERR, "wr_id");
    wr(A_W + 8'd36, 32'h1, SLVERR, "wr_w_oob");

    // Clear-then-start in one write.
    wr(A_CTRL, 32'h3, OKAY, "clr_start");
    rd_chk(A_CTRL, 32'h4, OKAY, "clr_start_ctrl");
    wait_done("clr_start");

    // W1C committing on the same edge the run finishes.
    set_cfg(shift_m, relu_m, 1);
    wr(A_CTRL, 32'h1, OKAY, "coin_start");
    sb = bv_cycle;
    d = sb + TAPS - cyc;
    if (d < 0) d = 0;
    axi_write(A_CTRL, 32'h2, d, d, 0, r);
    check_eq("coin_resp", {30'd0, r}, {30'd0, OKAY});
    check_eq("coin_irq", {31'd0, irq}, 1);
    rd_chk(A_CTRL, 32'h2, OKAY, "coin_ctrl");
    rd_chk(A_OUT, model_out(), OKAY, "coin_out");

    // Randomised runs.
    for (int t = 0; t < 6; t++) begin
      int k;
      for (int i = 0; i < TAPS; i++) begin
        in_m[i] = $urandom_range(0, 255) - 128;
        w_m[i]  = $urandom_range(0, 255) - 128;
      end
      set_cfg($urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      load_ops(1);
      run_conv("rand");
      k = $urandom_range(0, TAPS - 1);
      rd_chk(A_IN + 8'(4 * k), 32'(in_m[k]), OKAY, "rand_in_rb");
      rd_chk(A_W + 8'(4 * k), 32'(w_m[k]), OKAY, "rand_w_rb");
      check_eq("rand_irq", {31'd0, irq}, {31'd0, irq_en_m});
    end

    // Reset in the middle of a run.
    wr(A_CTRL, 32'h1, OKAY, "mid_start");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("mid_rst_quiet");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_chk(A_CTRL, 32'h0, OKAY, "mid_ctrl");
    rd_chk(A_OUT, 32'h0, OKAY, "mid_out");
    rd_chk(A_CFG, 32'h0, OKAY, "mid_cfg");
    rd_chk(A_IN, 32'h0, OKAY, "mid_in0");
    for (int i = 0; i < TAPS; i++) begin
      in_m[i] = $urandom_range(0, 255) - 128;
      w_m[i]  = $urandom_range(0, 255) - 128;
    end
    set_cfg(1, 0, 0);
    load_ops(0);
    run_conv("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
